// File: rtl/mastermind_board_renderer.sv
`default_nettype none
//==============================================================================
// mastermind_board_renderer: committed-row history plus a 2-stage pixel colour
// pipeline for a 480x800 portrait Mastermind board.          Revision: 1.0
//==============================================================================
module mastermind_board_renderer #(
  parameter int ROW_H     = 100,
  parameter int COL_W     = 96,
  parameter int INSET     = 8,
  parameter int PEG_INSET = 6
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       iStart,
  input  logic [2:0] iRow,
  input  logic [2:0] iVal1,
  input  logic [2:0] iVal2,
  input  logic [2:0] iVal3,
  input  logic [2:0] iVal4,
  input  logic [2:0] iWhite,
  input  logic [2:0] iBlack,
  input  logic       iNextRound,
  input  logic       iPixValid,
  input  logic [9:0] iPixX,
  input  logic [9:0] iPixY,
  output logic       oPixValid,
  output logic [7:0] oRed,
  output logic [7:0] oGreen,
  output logic [7:0] oBlue,
  output logic [3:0] oCommitted
);

  localparam int          C_PEG_X     = 4 * COL_W;
  localparam int          C_SCR_W     = 5 * COL_W;
  localparam int          C_SCR_H     = 8 * ROW_H;
  localparam int          C_SUB_W     = COL_W / 2;
  localparam int          C_SUB_H     = ROW_H / 2;
  localparam int          C_ROW_INSET = 10;
  localparam logic [6:0]  C_CELL_X_LO = 7'(INSET);
  localparam logic [6:0]  C_CELL_X_HI = 7'(COL_W - 1 - INSET);
  localparam logic [6:0]  C_CELL_Y_LO = 7'(C_ROW_INSET);
  localparam logic [6:0]  C_CELL_Y_HI = 7'(ROW_H - 1 - C_ROW_INSET);
  localparam logic [6:0]  C_PEG_X_LO  = 7'(PEG_INSET);
  localparam logic [6:0]  C_PEG_X_HI  = 7'(C_SUB_W - 1 - PEG_INSET);
  localparam logic [6:0]  C_PEG_Y_HI  = 7'(C_SUB_H - 1 - PEG_INSET);
  localparam logic [6:0]  C_SUB_W7    = 7'(C_SUB_W);
  localparam logic [6:0]  C_SUB_H7    = 7'(C_SUB_H);
  localparam logic [23:0] C_BG        = 24'h8B5A2B;
  localparam logic [23:0] C_BORDER    = 24'hE0C000;
  localparam logic [23:0] C_EMPTY     = 24'h404040;
  localparam logic [23:0] C_WHITE     = 24'hFFFFFF;
  localparam logic [23:0] C_BLACK     = 24'h000000;

  function automatic logic [23:0] val_colour(input logic [2:0] v);
    case (v)
      3'd1:    val_colour = 24'hFF0000;
      3'd2:    val_colour = 24'h00FF00;
      3'd3:    val_colour = 24'h0000FF;
      3'd4:    val_colour = 24'hFFFF00;
      3'd5:    val_colour = 24'hFF00FF;
      3'd6:    val_colour = 24'h00FFFF;
      default: val_colour = C_EMPTY;
    endcase
  endfunction

  // Row history; guess values packed as {v4, v3, v2, v1}
  logic [7:0]  valid_q;
  logic [11:0] vals_q  [8];
  logic [2:0]  white_q [8];
  logic [2:0]  black_q [8];
  logic        prev_q;
  logic [3:0]  committed_q;
  logic        commit;

  assign commit = iNextRound & ~prev_q;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q     <= '0;
      prev_q      <= 1'b0;
      committed_q <= '0;
      for (int r = 0; r < 8; r++) begin
        vals_q[r]  <= '0;
        white_q[r] <= '0;
        black_q[r] <= '0;
      end
    end else begin
      prev_q <= iNextRound;
      if (!iStart) begin
        valid_q     <= '0;
        committed_q <= '0;
      end else if (commit) begin
        valid_q[iRow] <= 1'b1;
        vals_q[iRow]  <= {iVal4, iVal3, iVal2, iVal1};
        white_q[iRow] <= iWhite;
        black_q[iRow] <= iBlack;
        if (!valid_q[iRow] && committed_q != 4'd8)
          committed_q <= committed_q + 4'd1;
      end
    end
  end

  // Stage 1: split the coordinate into row/column and local offsets
  logic [2:0] row_d, row_q;
  logic [6:0] ly_d, ly_q, lx_d, lx_q;
  logic [1:0] col_d, col_q;
  logic       peg_d, peg_q, oor_d, oor_q, s1_valid_q;

  always_comb begin
    row_d = 3'd7;
    ly_d  = 7'(iPixY - 10'(7 * ROW_H));
    for (int r = 6; r >= 0; r--) begin
      if (iPixY < 10'((r + 1) * ROW_H)) begin
        row_d = 3'(r);
        ly_d  = 7'(iPixY - 10'(r * ROW_H));
      end
    end
    col_d = 2'd3;
    peg_d = 1'b1;
    lx_d  = 7'(iPixX - 10'(C_PEG_X));
    if (iPixX < 10'(C_PEG_X)) begin
      peg_d = 1'b0;
      lx_d  = 7'(iPixX - 10'(3 * COL_W));
      for (int c = 2; c >= 0; c--) begin
        if (iPixX < 10'((c + 1) * COL_W)) begin
          col_d = 2'(c);
          lx_d  = 7'(iPixX - 10'(c * COL_W));
        end
      end
    end
    oor_d = (iPixX >= 10'(C_SCR_W)) || (iPixY >= 10'(C_SCR_H));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      s1_valid_q <= 1'b0;
      row_q      <= '0;
      ly_q       <= '0;
      col_q      <= '0;
      peg_q      <= 1'b0;
      lx_q       <= '0;
      oor_q      <= 1'b0;
    end else begin
      s1_valid_q <= iPixValid;
      row_q      <= row_d;
      ly_q       <= ly_d;
      col_q      <= col_d;
      peg_q      <= peg_d;
      lx_q       <= lx_d;
      oor_q      <= oor_d;
    end
  end

  // Stage 2: colour lookup against the history as it stands this cycle
  logic        row_valid, live, in_cell, in_peg;
  logic [11:0] row_vals;
  logic [2:0]  row_white, row_black, cell_val;
  logic [6:0]  sx, sy;
  logic [1:0]  slot;
  logic [3:0]  pegs_sum, pegs_lit;
  logic [23:0] colour_d, colour_q;
  logic        pix_valid_q;

  always_comb begin
    row_valid = valid_q[row_q];
    live      = (row_q == iRow) && !row_valid;
    row_vals  = '0;
    row_white = '0;
    row_black = '0;
    if (row_valid) begin
      row_vals  = vals_q[row_q];
      row_white = white_q[row_q];
      row_black = black_q[row_q];
    end else if (live) begin
      row_vals  = {iVal4, iVal3, iVal2, iVal1};
    end
    case (col_q)
      2'd0:    cell_val = row_vals[2:0];
      2'd1:    cell_val = row_vals[5:3];
      2'd2:    cell_val = row_vals[8:6];
      default: cell_val = row_vals[11:9];
    endcase
    sx       = (lx_q >= C_SUB_W7) ? lx_q - C_SUB_W7 : lx_q;
    sy       = (ly_q >= C_SUB_H7) ? ly_q - C_SUB_H7 : ly_q;
    slot     = {ly_q >= C_SUB_H7, lx_q >= C_SUB_W7};
    pegs_sum = {1'b0, row_black} + {1'b0, row_white};
    pegs_lit = (pegs_sum > 4'd4) ? 4'd4 : pegs_sum;
    in_cell  = (lx_q >= C_CELL_X_LO) && (lx_q <= C_CELL_X_HI) &&
               (ly_q >= C_CELL_Y_LO) && (ly_q <= C_CELL_Y_HI);
    in_peg   = (sx >= C_PEG_X_LO) && (sx <= C_PEG_X_HI) &&
               (sy >= C_PEG_X_LO) && (sy <= C_PEG_Y_HI);
    if (oor_q)
      colour_d = C_BLACK;
    else if (!peg_q)
      colour_d = in_cell ? val_colour(cell_val) : (live ? C_BORDER : C_BG);
    else if (!in_peg)
      colour_d = C_BG;
    else if ({1'b0, slot} < row_black)
      colour_d = C_BLACK;
    else if ({2'b0, slot} < pegs_lit)
      colour_d = C_WHITE;
    else
      colour_d = C_EMPTY;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pix_valid_q <= 1'b0;
      colour_q    <= '0;
    end else begin
      pix_valid_q <= s1_valid_q;
      colour_q    <= colour_d;
    end
  end

  assign oPixValid  = pix_valid_q;
  assign oRed       = colour_q[23:16];
  assign oGreen     = colour_q[15:8];
  assign oBlue      = colour_q[7:0];
  assign oCommitted = committed_q;

endmodule
`default_nettype wire

// File: tb/tb_mastermind_board_renderer.sv
`default_nettype none
//==============================================================================
// tb_mastermind_board_renderer: directed board scenarios plus a randomized run
// checked every cycle against a geometric reference model.    Revision: 1.0
//==============================================================================
module tb_mastermind_board_renderer;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       iStart = 1'b0;
  logic [2:0] iRow = 3'd0;
  logic [2:0] iVal1 = 3'd0, iVal2 = 3'd0, iVal3 = 3'd0, iVal4 = 3'd0;
  logic [2:0] iWhite = 3'd0, iBlack = 3'd0;
  logic       iNextRound = 1'b0;
  logic       iPixValid = 1'b0;
  logic [9:0] iPixX = 10'd0, iPixY = 10'd0;
  logic       oPixValid;
  logic [7:0] oRed, oGreen, oBlue;
  logic [3:0] oCommitted;

  mastermind_board_renderer dut (
    .clock(clock), .reset(reset), .iStart(iStart), .iRow(iRow),
    .iVal1(iVal1), .iVal2(iVal2), .iVal3(iVal3), .iVal4(iVal4),
    .iWhite(iWhite), .iBlack(iBlack), .iNextRound(iNextRound),
    .iPixValid(iPixValid), .iPixX(iPixX), .iPixY(iPixY),
    .oPixValid(oPixValid), .oRed(oRed), .oGreen(oGreen), .oBlue(oBlue),
    .oCommitted(oCommitted)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: board state and the response expected after each edge
  bit          m_valid [8];
  int          m_val   [8][4];
  int          m_white [8];
  int          m_black [8];
  bit          m_prev = 1'b0;
  bit          r1_v = 1'b0;
  int          r1_x = 0, r1_y = 0;
  bit          e_v = 1'b0;
  logic [23:0] e_col = 24'h0;

  function automatic logic [23:0] pal(input int v);
    case (v)
      1: return 24'hFF0000;
      2: return 24'h00FF00;
      3: return 24'h0000FF;
      4: return 24'hFFFF00;
      5: return 24'hFF00FF;
      6: return 24'h00FFFF;
      default: return 24'h404040;
    endcase
  endfunction

  function automatic int count_valid();
    int n = 0;
    for (int r = 0; r < 8; r++) if (m_valid[r]) n++;
    return n;
  endfunction

  function automatic logic [23:0] model_pixel(input int x, input int y);
    int  row, ly, lx, col, v, sx, sy, k, b, w, n;
    int  lv [4];
    bit  stored, live;
    if (x >= 480 || y >= 800) return 24'h000000;
    lv[0] = int'(iVal1); lv[1] = int'(iVal2); lv[2] = int'(iVal3); lv[3] = int'(iVal4);
    row    = y / 100;
    ly     = y % 100;
    stored = m_valid[row];
    live   = (row == int'(iRow)) && !stored;
    if (x < 384) begin
      col = x / 96;
      lx  = x % 96;
      v   = stored ? m_val[row][col] : (live ? lv[col] : 0);
      if (lx >= 8 && lx <= 87 && ly >= 10 && ly <= 89) return pal(v);
      return live ? 24'hE0C000 : 24'h8B5A2B;
    end
    lx = x - 384;
    sx = lx % 48;
    sy = ly % 50;
    k  = (ly >= 50 ? 2 : 0) + (lx >= 48 ? 1 : 0);
    b  = stored ? m_black[row] : 0;
    w  = stored ? m_white[row] : 0;
    n  = (b + w > 4) ? 4 : b + w;
    if (!(sx >= 6 && sx <= 41 && sy >= 6 && sy <= 43)) return 24'h8B5A2B;
    if (k < b) return 24'h000000;
    if (k < n) return 24'hFFFFFF;
    return 24'h404040;
  endfunction

  initial forever begin
    @(posedge clock or negedge reset);
    if (!reset) begin
      for (int r = 0; r < 8; r++) m_valid[r] = 1'b0;
      m_prev = 1'b0;
      r1_v   = 1'b0;
      e_v    = 1'b0;
    end else begin
      e_v   = r1_v;
      e_col = model_pixel(r1_x, r1_y);
      if (!iStart) begin
        for (int r = 0; r < 8; r++) m_valid[r] = 1'b0;
      end else if (iNextRound && !m_prev) begin
        m_valid[iRow]    = 1'b1;
        m_val[iRow][0]   = int'(iVal1);
        m_val[iRow][1]   = int'(iVal2);
        m_val[iRow][2]   = int'(iVal3);
        m_val[iRow][3]   = int'(iVal4);
        m_white[iRow]    = int'(iWhite);
        m_black[iRow]    = int'(iBlack);
      end
      m_prev = iNextRound;
      r1_v   = iPixValid;
      r1_x   = int'(iPixX);
      r1_y   = int'(iPixY);
    end
  end

  initial forever begin
    @(negedge clock);
    check("model valid", 32'(oPixValid), 32'(e_v));
    if (e_v) check("model colour", 32'({oRed, oGreen, oBlue}), 32'(e_col));
    check("model committed", 32'(oCommitted), 32'(count_valid()));
  end

  task automatic probe(input string name, input int x, input int y, input logic [23:0] exp);
    @(negedge clock);
    iPixValid = 1'b1;
    iPixX     = 10'(x);
    iPixY     = 10'(y);
    @(negedge clock);
    iPixValid = 1'b0;
    check({name, " early"}, 32'(oPixValid), 32'd0);
    @(negedge clock);
    check({name, " valid"}, 32'(oPixValid), 32'd1);
    check(name, 32'({oRed, oGreen, oBlue}), 32'(exp));
  endtask

  task automatic idle(input int n);
    iPixValid = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("reset valid", 32'(oPixValid), 32'd0);
    check("reset colour", 32'({oRed, oGreen, oBlue}), 32'd0);
    check("reset committed", 32'(oCommitted), 32'd0);
    reset = 1'b1;
    iStart = 1'b1;
    iRow = 3'd7;
    idle(2);
    check("start committed", 32'(oCommitted), 32'd0);
    probe("live empty", 40, 750, 24'h404040);

    iVal1 = 3'd1; iVal2 = 3'd2; iVal3 = 3'd3; iVal4 = 3'd4;
    probe("live col0", 48, 750, 24'hFF0000);
    probe("live col3", 336, 750, 24'hFFFF00);
    probe("live border", 2, 705, 24'hE0C000);

    @(negedge clock);
    iWhite = 3'd2; iBlack = 3'd1; iNextRound = 1'b1;
    @(negedge clock);
    check("commit count", 32'(oCommitted), 32'd1);
    probe("peg k0", 408, 725, 24'h000000);
    probe("peg k1", 456, 725, 24'hFFFFFF);
    probe("peg k2", 408, 775, 24'hFFFFFF);
    probe("peg k3", 456, 775, 24'h404040);
    probe("stored border", 2, 705, 24'h8B5A2B);

    repeat (5) begin
      @(negedge clock);
      check("held nextround", 32'(oCommitted), 32'd1);
    end
    iRow = 3'd6;
    iVal1 = 3'd5; iVal2 = 3'd6; iVal3 = 3'd5; iVal4 = 3'd6;
    probe("stored col0", 48, 750, 24'hFF0000);
    probe("stored col3", 336, 750, 24'hFFFF00);
    probe("row6 live", 48, 650, 24'hFF00FF);
    check("no extra commit", 32'(oCommitted), 32'd1);

    @(negedge clock);
    iNextRound = 1'b0;
    @(negedge clock);
    iRow = 3'd7; iStart = 1'b0; iNextRound = 1'b1;
    @(negedge clock);
    check("clear wins", 32'(oCommitted), 32'd0);
    iStart = 1'b1;
    iVal1 = 3'd0;
    probe("cleared live", 48, 750, 24'h404040);
    probe("cleared border", 2, 705, 24'hE0C000);
    probe("out of range", 479, 800, 24'h000000);
    iNextRound = 1'b0;

    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      iPixValid = ($urandom_range(0, 3) != 0);
      iPixX     = 10'($urandom_range(0, 519));
      iPixY     = 10'($urandom_range(0, 839));
      if ($urandom_range(0, 5) == 0) iNextRound = ~iNextRound;
      if ($urandom_range(0, 11) == 0) iRow = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) iVal1 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) iVal2 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) iVal3 = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) iVal4 = 3'($urandom_range(0, 7));
      iWhite = 3'($urandom_range(0, 5));
      iBlack = 3'($urandom_range(0, 5));
      iStart = ($urandom_range(0, 599) != 0);
    end
    iStart = 1'b1;
    idle(3);

    for (int i = 0; i < 16; i++) begin
      if (i == 9) begin
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("reset drops valid", 32'(oPixValid), 32'd0);
        iPixValid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        for (int j = 0; j < 3; j++) begin
          @(negedge clock);
          check("no stale response", 32'(oPixValid), 32'd0);
        end
      end else begin
        @(negedge clock);
        iPixValid = 1'b1;
        iPixX     = 10'($urandom_range(0, 479));
        iPixY     = 10'($urandom_range(0, 799));
      end
    end
    idle(4);
    check("idle after stream", 32'(oPixValid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
